demux_sel_sequencer: RTL and testbench
======================================

// Module: demux_sel_sequencer
// PURPOSE
//  Upstream driver for the 1x8 behavioural demux: owns its select bus and data
//  input. Accepts one (data bit, channel) request per valid/ready handshake.
//  Drives sel/d_out for a programmable hold time, then a break-before-make gap
//  with d_out=0 before the next request. Auto mode replaces the requested channel
//  with an internal round-robin pointer (0..7) for channel sweeps.
// PARAMETERS
//  SEL_W        3   select width; channel count = 2**SEL_W (8)
//  HOLD_CYCLES  4   cycles sel/d_out are driven per request; legal >= 1
//  GAP_CYCLES   1   cycles d_out forced 0 after each hold; 0 = no gap state
// PORTS
//  clk         in   1      single clock, all state on rising edge
//  rst_n       in   1      synchronous, active-low reset
//  in_valid    in   1      request present
//  in_ready    out  1      sequencer can accept a request
//  in_data     in   1      bit to route (demux D)
//  in_chan     in   SEL_W  target channel; ignored when auto_mode=1
//  auto_mode   in   1      1 = use round-robin pointer; sampled at accept
//  sel         out  SEL_W  to demux select
//  d_out       out  1      to demux data input
//  busy        out  1      1 in DRIVE or GAP
//  done        out  1      1-cycle pulse on last gap cycle (last hold if GAP=0)
//  sweep_done  out  1      1-cycle pulse with done when auto pointer wraps 7->0
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=IDLE, sel=0, d_out=0, busy=0, done=0,
//    sweep_done=0, pointer=0, counter=0; in_ready=0 while rst_n=0.
//  - States: IDLE -> DRIVE -> GAP -> IDLE; DRIVE -> IDLE direct if GAP_CYCLES=0.
//  - IDLE: in_ready=1, d_out=0, sel holds last value. Accept when in_valid &&
//    in_ready at edge k: latch data and channel (in_chan or pointer); enter DRIVE.
//  - DRIVE: from cycle k+1, sel=latched channel, d_out=latched data, for exactly
//    HOLD_CYCLES cycles; in_ready=0.
//  - GAP: d_out=0, sel unchanged, GAP_CYCLES cycles; in_ready=0.
//  - done asserted in final busy cycle; in_ready=1 next cycle (IDLE). No
//    back-to-back accept while busy: throughput one request per HOLD+GAP+1 cycles.
//  - Auto pointer advances by 1 (mod 2**SEL_W) only on an auto-mode accept;
//    manual accepts leave it unchanged. sweep_done pulses with done of the
//    transfer that used channel 7 in auto mode.
//  - in_chan/in_data/auto_mode changes during DRIVE/GAP have no effect.
//  - in_valid may drop without accept; no request is remembered.
//  - Reset mid-DRIVE/GAP: transfer discarded, no done, all outputs to reset values.
//  - Down counter width = clog2(max(HOLD_CYCLES,GAP_CYCLES)+1); loaded at
//    state entry, transition when it reaches 1.
// STRUCTURE
//  - demux_pkg: state encoding (IDLE=2'd0, DRIVE=2'd1, GAP=2'd2), SEL_W default,
//    NUM_CH = 2**SEL_W constant.
//  - One sub-module: demux_hold_timer (load value, load strobe, expired flag).
//  - FSM, latches and pointer in top; all outputs registered.
// TESTING
//  - Reset: rst_n=0 for 2 cycles -> sel=000, d_out=0, in_ready=0, busy=0;
//    release -> in_ready=1 next cycle.
//  - Manual: in_chan=101, in_data=1, valid 1 cycle -> sel=101, d_out=1 for
//    4 cycles, d_out=0 1 cycle with done=1, in_ready=1 after; 6 cycles total.
//  - Auto sweep: auto_mode=1, valid held high, data=1 -> sel 000..111 in order,
//    one done per channel, sweep_done only with channel 111's done; next is 000.
//  - Mixed: auto accept (ch 0), manual ch 110, auto accept -> second auto uses
//    channel 001 (pointer not moved by manual).
//  - Busy ignore: in_chan/in_data toggled during DRIVE -> sel/d_out unchanged;
//    in_valid during busy not accepted.
//  - Reset mid-DRIVE at cycle 2 -> next cycle sel=000, d_out=0, no done pulse;
//    pointer back to 0. Repeat with GAP_CYCLES=0: done on 4th hold cycle.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and constants for the demux select sequencer.
package demux_pkg;

    localparam int SEL_W_DEF = 3;
    localparam int NUM_CH    = 2 ** SEL_W_DEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // Width of a down counter that must hold the larger of the two phase lengths.
    function automatic int cnt_width(input int hold, input int gap);
        int m;
        m = (hold > gap) ? hold : gap;
        return $clog2(m + 32'sd1);
    endfunction

endpackage

// File: rtl/demux_hold_timer.sv
// Loadable down counter; expired marks the last cycle of a loaded phase.
module demux_hold_timer
    import demux_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired,
    output logic             expire_next
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign expired     = (cnt_q == CNT_ONE);
    assign expire_next = (cnt_d == CNT_ONE);

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/demux_sel_sequencer.sv
// Drives a 1xN demux select/data pair: one request per handshake, held for a
// fixed time, then a break-before-make gap; optional round-robin channel sweep.
module demux_sel_sequencer
    import demux_pkg::*;
#(
    parameter int SEL_W       = SEL_W_DEF,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_data,
    input  logic [SEL_W-1:0] in_chan,
    input  logic             auto_mode,
    output logic [SEL_W-1:0] sel,
    output logic             d_out,
    output logic             busy,
    output logic             done,
    output logic             sweep_done
);

    localparam int               CNT_W    = cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_V   = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] GAP_V    = CNT_W'(GAP_CYCLES);
    localparam logic             HAS_GAP  = (GAP_CYCLES > 32'sd0);
    localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
    localparam logic [SEL_W-1:0] LAST_CH  = '1;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             data_q, data_d;
    logic             auto_q, auto_d;
    logic             in_ready_q, in_ready_d;
    logic             d_out_q, d_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sweep_q, sweep_d;

    logic             accept_s;
    logic             load_s;
    logic [CNT_W-1:0] load_val_s;
    logic             expired_s;
    logic             expire_next_s;

    assign accept_s = in_valid && in_ready_q;

    demux_hold_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load_s),
        .load_val    (load_val_s),
        .expired     (expired_s),
        .expire_next (expire_next_s)
    );

    // Next state, request latches, pointer and timer loads.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        data_d     = data_q;
        auto_d     = auto_q;
        load_s     = 1'b0;
        load_val_s = HOLD_V;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d    = ST_DRIVE;
                    load_s     = 1'b1;
                    load_val_s = HOLD_V;
                    data_d     = in_data;
                    auto_d     = auto_mode;
                    if (auto_mode) begin
                        sel_d = ptr_q;
                        ptr_d = ptr_q + SEL_ONE;
                    end else begin
                        sel_d = in_chan;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (expired_s) begin
                    if (HAS_GAP) begin
                        state_d    = ST_GAP;
                        load_s     = 1'b1;
                        load_val_s = GAP_V;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_DRIVE;
                end
            end
            ST_GAP: begin
                if (expired_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle; done marks the final busy cycle.
    always_comb begin
        in_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
        d_out_d    = (state_d == ST_DRIVE) ? data_d : 1'b0;
        done_d     = ((state_d == ST_GAP) || ((state_d == ST_DRIVE) && !HAS_GAP)) && expire_next_s;
        sweep_d    = done_d && auto_d && (sel_d == LAST_CH);
    end

    // State and output registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            ptr_q      <= '0;
            data_q     <= 1'b0;
            auto_q     <= 1'b0;
            in_ready_q <= 1'b0;
            d_out_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sweep_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            data_q     <= data_d;
            auto_q     <= auto_d;
            in_ready_q <= in_ready_d;
            d_out_q    <= d_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sweep_q    <= sweep_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign sel        = sel_q;
    assign d_out      = d_out_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign sweep_done = sweep_q;

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Bench for demux_sel_sequencer: two instances (gap 1 and gap 0) against a
// transfer-schedule reference model, directed scenarios plus random traffic.
module tb_demux_sel_sequencer;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_data;
    logic [2:0] in_chan;
    logic       auto_mode;

    logic       r0, b0, dn0, sw0, d0;
    logic [2:0] s0;
    logic       r1, b1, dn1, sw1, d1;
    logic [2:0] s1;

    demux_sel_sequencer #(.SEL_W(3), .HOLD_CYCLES(HOLD), .GAP_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r0),
        .in_data(in_data), .in_chan(in_chan), .auto_mode(auto_mode),
        .sel(s0), .d_out(d0), .busy(b0), .done(dn0), .sweep_done(sw0));

    demux_sel_sequencer #(.SEL_W(3), .HOLD_CYCLES(HOLD), .GAP_CYCLES(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r1),
        .in_data(in_data), .in_chan(in_chan), .auto_mode(auto_mode),
        .sel(s1), .d_out(d1), .busy(b1), .done(dn1), .sweep_done(sw1));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    function automatic int gap_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    // Reference model: per instance, the active transfer and the cycle offset into it.
    bit         m_act[2];
    int         m_off[2];
    logic [2:0] m_ch[2];
    bit         m_dat[2];
    bit         m_au[2];
    int         m_ptr[2];
    logic [2:0] m_last[2];
    bit         e_ready[2], e_busy[2], e_done[2], e_sweep[2], e_d[2];
    logic [2:0] e_sel[2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_act[i] = 1'b0; m_ptr[i] = 0; m_last[i] = 3'd0;
                e_ready[i] = 1'b0; e_busy[i] = 1'b0; e_done[i] = 1'b0;
                e_sweep[i] = 1'b0; e_d[i] = 1'b0; e_sel[i] = 3'd0;
            end else begin
                if (m_act[i]) begin
                    m_off[i]++;
                    if (m_off[i] > HOLD + gap_of(i)) m_act[i] = 1'b0;
                end
                if (in_valid && e_ready[i]) begin
                    m_act[i] = 1'b1;
                    m_off[i] = 1;
                    m_dat[i] = in_data;
                    m_au[i]  = auto_mode;
                    m_ch[i]  = auto_mode ? 3'(m_ptr[i]) : in_chan;
                    if (auto_mode) m_ptr[i] = (m_ptr[i] + 1) % 8;
                end
                if (m_act[i]) begin
                    m_last[i]  = m_ch[i];
                    e_ready[i] = 1'b0;
                    e_busy[i]  = 1'b1;
                    e_sel[i]   = m_ch[i];
                    e_d[i]     = (m_off[i] <= HOLD) ? m_dat[i] : 1'b0;
                    e_done[i]  = (m_off[i] == HOLD + gap_of(i));
                    e_sweep[i] = e_done[i] && m_au[i] && (m_ch[i] == 3'd7);
                end else begin
                    e_ready[i] = 1'b1; e_busy[i] = 1'b0; e_done[i] = 1'b0;
                    e_sweep[i] = 1'b0; e_d[i] = 1'b0; e_sel[i] = m_last[i];
                end
            end
        end
    end

    logic [7:0] cmp_got, cmp_want;

    // Every cycle, both instances against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            cmp_got  = (i == 0) ? {r0, b0, dn0, sw0, d0, s0} : {r1, b1, dn1, sw1, d1, s1};
            cmp_want = {e_ready[i], e_busy[i], e_done[i], e_sweep[i], e_d[i], e_sel[i]};
            n_vec++;
            if (cmp_got !== cmp_want) begin
                n_err++;
                $display("FAIL model_cmp dut%0d t=%0t got rdy/busy/done/sweep/d/sel=%b want=%b",
                         i, $time, cmp_got, cmp_want);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, got, want);
        end
    endtask

    // One request issued from an idle cycle; returns the selects seen in the first drive cycle.
    task automatic send(input logic a, input logic [2:0] c, input logic d,
                        output logic [2:0] fs0, output logic [2:0] fs1);
        in_valid = 1'b1; auto_mode = a; in_chan = c; in_data = d;
        @(negedge clk);
        in_valid = 1'b0;
        fs0 = s0; fs1 = s1;
        repeat (5) @(negedge clk);
    endtask

    logic [2:0] fa, fb;
    int         ndone, nsw, nbad;
    logic [2:0] swsel;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 1'b0; in_chan = 3'd0; auto_mode = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_sel", 32'(s0), 32'd0);
        chk("rst_dout", 32'(d0), 32'd0);
        chk("rst_ready", 32'(r0), 32'd0);
        chk("rst_busy", 32'(b0), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_ready", 32'(r0), 32'd1);

        // Manual request to channel 5
        in_valid = 1'b1; in_chan = 3'b101; in_data = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k <= 5) chk("man_sel", 32'(s0), 32'd5);
            chk("man_dout", 32'(d0), (k <= 4) ? 32'd1 : 32'd0);
            chk("man_done", 32'(dn0), (k == 5) ? 32'd1 : 32'd0);
            chk("man_ready", 32'(r0), (k == 6) ? 32'd1 : 32'd0);
            chk("man_nogap_done", 32'(dn1), (k == 4) ? 32'd1 : 32'd0);
            @(negedge clk);
        end

        // Auto sweep with valid held high
        auto_mode = 1'b1; in_valid = 1'b1; in_data = 1'b1;
        ndone = 0; nsw = 0; swsel = 3'd0;
        for (int j = 0; j < 56; j++) begin
            @(negedge clk);
            if (j == 47) in_valid = 1'b0;
            if (dn0) ndone++;
            if (sw0) begin nsw++; swsel = s0; end
        end
        chk("sweep_dones", 32'(ndone), 32'd8);
        chk("sweep_pulses", 32'(nsw), 32'd1);
        chk("sweep_chan", 32'(swsel), 32'd7);
        send(1'b1, 3'd0, 1'b1, fa, fb);
        chk("sweep_wrap_sel", 32'(fa), 32'd0);

        // Mixed auto/manual after a reset
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(1'b1, 3'd3, 1'b1, fa, fb);
        chk("mixed_a0", 32'(fa), 32'd0);
        send(1'b0, 3'd6, 1'b0, fa, fb);
        chk("mixed_m6", 32'(fa), 32'd6);
        send(1'b1, 3'd5, 1'b1, fa, fb);
        chk("mixed_a1_dut0", 32'(fa), 32'd1);
        chk("mixed_a1_dut1", 32'(fb), 32'd1);

        // Inputs toggled and valid held while busy
        in_valid = 1'b1; auto_mode = 1'b0; in_chan = 3'd3; in_data = 1'b1;
        @(negedge clk);
        in_chan = 3'd4; in_data = 1'b0; auto_mode = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            chk("busy_sel", 32'(s0), 32'd3);
            chk("busy_dout", 32'(d0), 32'd1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("busy_gap_ready", 32'(r0), 32'd0);
        @(negedge clk);
        chk("busy_no_accept", 32'(b0), 32'd0);
        chk("busy_idle_ready", 32'(r0), 32'd1);

        // Reset during drive
        in_valid = 1'b1; auto_mode = 1'b0; in_chan = 3'd5; in_data = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_sel", 32'(s0), 32'd0);
        chk("midrst_dout", 32'(d0), 32'd0);
        chk("midrst_busy", 32'(b0), 32'd0);
        chk("midrst_ready", 32'(r0), 32'd0);
        chk("midrst_sel_nogap", 32'(s1), 32'd0);
        rst_n = 1'b1;
        nbad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (dn0 || dn1) nbad++;
        end
        chk("midrst_no_done", 32'(nbad), 32'd0);
        send(1'b1, 3'd6, 1'b1, fa, fb);
        chk("midrst_ptr0", 32'(fa), 32'd0);

        // Random traffic with occasional reset
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 1'($urandom_range(0, 1));
            in_chan   = 3'($urandom_range(0, 7));
            auto_mode = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 99) != 0);
        end
        rst_n = 1'b1; in_valid = 1'b0;
        repeat (10) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
